// File: rtl/servo_slew.sv
// Eight-channel slew-rate limiter: per-channel target/rate registers, a tick divider,
// and a sweep FSM that steps one channel per cycle toward its target after every tick.
module servo_slew #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [4:0]  addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  rd_data,
  output logic [63:0] pwm_width,
  output logic [7:0]  busy
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  state_t          state, state_nx;
  logic [2:0]      idx, idx_nx;
  logic            upd;
  logic [23:0]     cnt;
  logic            tick;
  logic [7:0][7:0] target, rate, current;
  logic [7:0]      rd_mux;

  // Next width for one channel; 9-bit sums keep 0 and 255 reachable without wrap.
  function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] rt);
    logic [8:0] up, lim;
    up  = {1'b0, cur} + {1'b0, rt};
    lim = {1'b0, tgt} + {1'b0, rt};
    if (rt == 8'd0)      slew_step = tgt;
    else if (cur < tgt)  slew_step = (up >= {1'b0, tgt}) ? tgt : up[7:0];
    else if (cur > tgt)  slew_step = ({1'b0, cur} <= lim) ? tgt : cur - rt;
    else                 slew_step = cur;
  endfunction

  assign tick = (cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    upd      = 1'b0;
    case (state)
      IDLE: if (tick) begin
        state_nx = SWEEP;
        idx_nx   = 3'd0;
      end
      SWEEP: begin
        upd    = 1'b1;
        idx_nx = idx + 3'd1;
        if (idx == 3'd7) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 8'd0;
    case (addr[4:3])
      2'd0:    rd_mux = target[addr[2:0]];
      2'd1:    rd_mux = rate[addr[2:0]];
      2'd2:    rd_mux = current[addr[2:0]];
      default: rd_mux = 8'd0;
    endcase
  end

  // The sweep samples target/rate before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      rate    <= '0;
      current <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && !addr[4]) begin
        if (addr[3]) rate[addr[2:0]]   <= wr_data;
        else         target[addr[2:0]] <= wr_data;
      end
      if (upd) current[idx] <= slew_step(current[idx], target[idx], rate[idx]);
      if (rd_en) rd_data <= rd_mux;
    end
  end

  assign pwm_width = current;

  always_comb begin
    busy = '0;
    for (int k = 0; k < 8; k++) busy[k] = (current[k] != target[k]);
  end

endmodule

// File: tb/tb_servo_slew.sv
// Directed bench for servo_slew with TICK_DIV=16: register table plus hand-built sweep sequences.
module tb_servo_slew;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic [63:0] pwm_width;
  logic [7:0]  busy;

  int n_chk = 0;
  int n_fail = 0;
  int tc = 0;

  servo_slew #(.TICK_DIV(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .pwm_width(pwm_width), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference tick counter: value 15 marks the tick cycle.
  always @(posedge clk) begin
    if (rst) tc <= 0;
    else     tc <= (tc == 15) ? 0 : tc + 1;
  end

  typedef struct {
    logic       wr;
    logic       rd;
    logic       chk;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    rd_en = 1'b1; addr = a;
    step(1);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic wait_tick();
    int g;
    g = 0;
    while (tc != 15 && g < 64) begin
      step(1);
      g++;
    end
    if (tc != 15) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_tick: no tick cycle within 64 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] ramp_exp [5];
    logic [7:0] e;

    ramp_exp[0] = 8'd50;  ramp_exp[1] = 8'd100; ramp_exp[2] = 8'd150;
    ramp_exp[3] = 8'd180; ramp_exp[4] = 8'd180;

    //         wr    rd    chk   addr   data   exp
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd12, 8'd7,  8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd20, 8'd99, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 5'd12, 8'd0,  8'd7};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 5'd20, 8'd0,  8'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 5'd9,  8'd5,  8'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 5'd9,  8'd77, 8'd5};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 5'd9,  8'd0,  8'd77};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'd0,  8'd0,  8'd77};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 5'd30, 8'd55, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 5'd30, 8'd0,  8'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 5'd16, 8'd0,  8'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 5'd3,  8'd0,  8'd0};

    // Reset from a non-trivial state
    step(2);
    rst = 1'b0;
    wr(5'd0, 8'd200);
    rd(5'd0, d);
    chk("pre_reset_rd", 64'(d), 64'd200);
    wait_tick();
    step(3);
    chk("pre_reset_pwm0", 64'(pwm_width[7:0]), 64'd200);
    rst = 1'b1;
    step(1);
    chk("reset_pwm", pwm_width, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rd", 64'(rd_data), 64'd0);
    rst = 1'b0;
    for (int a = 0; a < 24; a++) begin
      rd(5'(a), d);
      chk($sformatf("reset_read_%0d", a), 64'(d), 64'd0);
    end

    // Register table
    for (int i = 0; i < 12; i++) begin
      wr_en = tbl[i].wr; rd_en = tbl[i].rd; addr = tbl[i].a; wr_data = tbl[i].d;
      step(1);
      wr_en = 1'b0; rd_en = 1'b0;
      if (tbl[i].chk) chk($sformatf("table_%0d", i), 64'(rd_data), 64'(tbl[i].exp));
    end

    // Immediate mode on channel 3
    do_reset();
    wr(5'd3, 8'd200);
    chk("imm_busy_early", 64'(busy), 64'h08);
    wait_tick();
    chk("imm_busy_tick", 64'(busy), 64'h08);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      e = (k >= 5) ? 8'd200 : 8'd0;
      chk($sformatf("imm_pwm_T%0d", k), pwm_width, 64'(e) << 24);
      chk($sformatf("imm_busy_T%0d", k), 64'(busy), (k >= 5) ? 64'h00 : 64'h08);
    end

    // Ramp up channel 0
    do_reset();
    wr(5'd8, 8'd50);
    wr(5'd0, 8'd180);
    for (int n = 0; n < 5; n++) begin
      wait_tick();
      step(9);
      chk($sformatf("ramp_pwm_%0d", n + 1), 64'(pwm_width[7:0]), 64'(ramp_exp[n]));
      chk($sformatf("ramp_busy_%0d", n + 1), 64'(busy[0]), (n < 3) ? 64'd1 : 64'd0);
    end

    // Ramp down without underflow on channel 1
    do_reset();
    wr(5'd1, 8'd20);
    wait_tick();
    step(9);
    chk("down_start", 64'(pwm_width[15:8]), 64'd20);
    wr(5'd9, 8'd30);
    wr(5'd1, 8'd0);
    wait_tick();
    for (int k = 1; k <= 9; k++) begin
      step(1);
      chk($sformatf("down_T%0d", k), 64'(pwm_width[15:8]), (k >= 3) ? 64'd0 : 64'd20);
    end

    // Ramp up without overflow on channel 2
    do_reset();
    wr(5'd2, 8'd250);
    wait_tick();
    step(9);
    chk("up_start", 64'(pwm_width[23:16]), 64'd250);
    wr(5'd10, 8'd10);
    wr(5'd2, 8'd255);
    wait_tick();
    step(9);
    chk("up_sat", 64'(pwm_width[23:16]), 64'd255);

    // Write collision with the sweep of channel 5
    do_reset();
    wr(5'd5, 8'd40);
    wait_tick();
    step(6);
    wr(5'd5, 8'd100);
    chk("coll_old", 64'(pwm_width[47:40]), 64'd40);
    chk("coll_busy", 64'(busy[5]), 64'd1);
    wait_tick();
    step(9);
    chk("coll_new", 64'(pwm_width[47:40]), 64'd100);

    // Reset in cycle T+4 of a sweep
    do_reset();
    wr(5'd0, 8'd10);
    wr(5'd1, 8'd20);
    wr(5'd2, 8'd30);
    wr(5'd3, 8'd40);
    wait_tick();
    step(4);
    chk("mid_partial", 64'(pwm_width[31:0]), 64'h001E140A);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_pwm", pwm_width, 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    step(20);
    chk("mid_after", pwm_width, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
